// File: rtl/sprite_pkg.sv
// Shared types and sizing helpers for the sprite mapper.
// Screen geometry, coordinate/scale types and the animation FSM states.
package sprite_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef logic [9:0] coord_t;
  typedef logic [1:0] scale_t;

  typedef enum logic {
    IDLE_VIS = 1'b0,
    SYNC     = 1'b1
  } anim_state_e;

  function automatic int addr_w(int nf, int w, int h);
    return $clog2(nf * w * h);
  endfunction

  function automatic int clog2_min1(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_anim_ctrl.sv
// Vsync edge detection, animation divider and frame selection.
// load_o pulses while the FSM leaves IDLE_VIS for SYNC.
module sprite_anim_ctrl
  import sprite_pkg::*;
#(
  parameter int NUM_FRAMES = 4,
  parameter int FRAME_DIV  = 8,
  localparam int FW = clog2_min1(NUM_FRAMES),
  localparam int VW = clog2_min1(FRAME_DIV)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vs,
  input  logic          anim_en,
  input  logic [FW-1:0] frame_sel,
  output logic [FW-1:0] frame_cur,
  output logic          load_o
);

  anim_state_e   state_q;
  logic [VW-1:0] vcnt_q;
  logic [FW-1:0] frame_q;
  logic          sel_bad;

  // State mirrors the previous vs sample, so IDLE_VIS with vs low is the fall.
  assign load_o    = (state_q == IDLE_VIS) & ~vs;
  assign frame_cur = frame_q;
  assign sel_bad   = {1'b0, frame_sel} >= (FW+1)'(NUM_FRAMES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE_VIS;
      vcnt_q  <= '0;
      frame_q <= '0;
    end else begin
      unique case (state_q)
        IDLE_VIS: begin
          if (!vs) begin
            state_q <= SYNC;
            if (!anim_en) begin
              vcnt_q  <= '0;
              frame_q <= sel_bad ? '0 : frame_sel;
            end else if (vcnt_q == VW'(FRAME_DIV - 1)) begin
              vcnt_q  <= '0;
              frame_q <= (frame_q == FW'(NUM_FRAMES - 1)) ? '0
                       : frame_q + FW'(1);
            end else begin
              vcnt_q <= vcnt_q + VW'(1);
            end
          end
        end
        SYNC: begin
          if (vs) state_q <= IDLE_VIS;
        end
        default: state_q <= IDLE_VIS;
      endcase
    end
  end

endmodule

// File: rtl/sprite_blit_mapper.sv
// Sprite placement/scaling pipeline: clip compare, ROM address, pixel out.
// Shadowed position/scale are reloaded on each vsync fall.
module sprite_blit_mapper
  import sprite_pkg::*;
#(
  parameter int SPR_W      = 32,
  parameter int SPR_H      = 32,
  parameter int NUM_FRAMES = 4,
  parameter int IDX_W      = 4,
  parameter int KEY_IDX    = 0,
  parameter int FRAME_DIV  = 8,
  localparam int ADDR_W = addr_w(NUM_FRAMES, SPR_W, SPR_H),
  localparam int FW     = clog2_min1(NUM_FRAMES)
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              vs,
  input  logic [9:0]        sprite_x,
  input  logic [9:0]        sprite_y,
  input  logic [1:0]        scale_log2,
  input  logic              anim_en,
  input  logic [FW-1:0]     frame_sel,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pix_idx,
  output logic              pix_on,
  output logic [FW-1:0]     frame_cur
);

  localparam int CB = $clog2(SPR_W);
  localparam int RB = $clog2(SPR_H);
  localparam int CW = FW + RB + CB;

  logic load;

  sprite_anim_ctrl #(
    .NUM_FRAMES (NUM_FRAMES),
    .FRAME_DIV  (FRAME_DIV)
  ) u_anim (
    .clk       (vga_clk),
    .rst_n     (reset_n),
    .vs        (vs),
    .anim_en   (anim_en),
    .frame_sel (frame_sel),
    .frame_cur (frame_cur),
    .load_o    (load)
  );

  coord_t sx_q, sy_q;
  scale_t s_q;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      sx_q <= '0;
      sy_q <= '0;
      s_q  <= '0;
    end else if (load) begin
      sx_q <= sprite_x;
      sy_q <= sprite_y;
      s_q  <= scale_log2;
    end
  end

  logic [10:0]       dx, dy;
  logic [11:0]       w_ext, h_ext;
  logic [9:0]        dxs, dys;
  logic [CW-1:0]     addr_full;
  logic              hit_d;
  logic [ADDR_W-1:0] addr_d;

  // Bit 10 is the sign: a negative offset never aliases onto the far edge.
  assign dx    = {1'b0, DrawX} - {1'b0, sx_q};
  assign dy    = {1'b0, DrawY} - {1'b0, sy_q};
  assign w_ext = 12'(SPR_W) << s_q;
  assign h_ext = 12'(SPR_H) << s_q;
  assign dxs   = dx[9:0] >> s_q;
  assign dys   = dy[9:0] >> s_q;

  assign hit_d = blank & ~dx[10] & ~dy[10]
               & ({1'b0, dx} < w_ext)
               & ({1'b0, dy} < h_ext);

  assign addr_full = {frame_cur, dys[RB-1:0], dxs[CB-1:0]};
  assign addr_d    = hit_d ? addr_full[ADDR_W-1:0] : '0;

  logic [ADDR_W-1:0] addr_q;
  logic              hit1_q, hit2_q;
  logic [IDX_W-1:0]  idx_q;
  logic              on_q;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
      hit1_q <= 1'b0;
      hit2_q <= 1'b0;
      idx_q  <= '0;
      on_q   <= 1'b0;
    end else begin
      addr_q <= addr_d;
      hit1_q <= hit_d;
      hit2_q <= hit1_q;
      idx_q  <= hit2_q ? rom_q : '0;
      on_q   <= hit2_q & (rom_q != IDX_W'(KEY_IDX));
    end
  end

  assign rom_address = addr_q;
  assign pix_idx     = idx_q;
  assign pix_on      = on_q;

endmodule

// File: tb/tb_sprite_blit_mapper.sv
// Randomised bench for sprite_blit_mapper against an arithmetic model.
// The model tracks shadows, frame counter and a 3-deep pixel pipeline.
module tb_sprite_blit_mapper;

  localparam int SPR_W = 32;
  localparam int SPR_H = 32;
  localparam int NF    = 3;
  localparam int IDX_W = 4;
  localparam int KEY   = 0;
  localparam int FDIV  = 2;
  localparam int AW    = 12;
  localparam int FW    = 2;

  logic             vga_clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [9:0]       DrawX = '0, DrawY = '0;
  logic             blank = 1'b0, vs = 1'b1, anim_en = 1'b0;
  logic [9:0]       sprite_x = '0, sprite_y = '0;
  logic [1:0]       scale_log2 = '0;
  logic [FW-1:0]    frame_sel = '0;
  logic [AW-1:0]    rom_address;
  logic [IDX_W-1:0] rom_q = '0;
  logic [IDX_W-1:0] pix_idx;
  logic             pix_on;
  logic [FW-1:0]    frame_cur;

  logic [IDX_W-1:0] rom_mem [0:4095];

  int checks = 0;
  int errors = 0;

  sprite_blit_mapper #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .NUM_FRAMES(NF),
    .IDX_W(IDX_W), .KEY_IDX(KEY), .FRAME_DIV(FDIV)
  ) dut (
    .vga_clk(vga_clk), .reset_n(reset_n),
    .DrawX(DrawX), .DrawY(DrawY), .blank(blank), .vs(vs),
    .sprite_x(sprite_x), .sprite_y(sprite_y),
    .scale_log2(scale_log2), .anim_en(anim_en),
    .frame_sel(frame_sel), .rom_address(rom_address),
    .rom_q(rom_q), .pix_idx(pix_idx), .pix_on(pix_on),
    .frame_cur(frame_cur)
  );

  always #5 vga_clk = ~vga_clk;

  always @(posedge vga_clk) rom_q <= rom_mem[rom_address];

  // Reference model state
  int sh_x, sh_y, sh_s, m_frame, m_vcnt;
  bit m_vsprev;
  bit m_hit1, m_hit2, m_on3;
  int m_addr1, m_a2, m_idx3;

  task automatic model_reset();
    sh_x = 0; sh_y = 0; sh_s = 0;
    m_frame = 0; m_vcnt = 0; m_vsprev = 1'b1;
    m_hit1 = 0; m_hit2 = 0; m_on3 = 0;
    m_addr1 = 0; m_a2 = 0; m_idx3 = 0;
  endtask

  // Advance one clock: model the edge, then sample #1 after it.
  task automatic tick();
    int x, y, ew, eh, a, sel;
    bit h;
    x = DrawX; y = DrawY;
    ew = SPR_W * (1 << sh_s);
    eh = SPR_H * (1 << sh_s);
    h = blank && x >= sh_x && x < sh_x + ew && y >= sh_y && y < sh_y + eh;
    a = 0;
    if (h)
      a = m_frame * SPR_W * SPR_H + ((y - sh_y) / (1 << sh_s)) * SPR_W
        + (x - sh_x) / (1 << sh_s);
    m_on3  = m_hit2 && (rom_mem[m_a2] != KEY);
    m_idx3 = m_hit2 ? int'(rom_mem[m_a2]) : 0;
    m_hit2 = m_hit1; m_a2 = m_addr1;
    m_hit1 = h; m_addr1 = a;
    if (m_vsprev && !vs) begin
      sh_x = sprite_x; sh_y = sprite_y; sh_s = scale_log2;
      if (!anim_en) begin
        sel = frame_sel;
        m_frame = (sel >= NF) ? 0 : sel;
        m_vcnt = 0;
      end else if (m_vcnt + 1 >= FDIV) begin
        m_vcnt = 0;
        m_frame = (m_frame + 1) % NF;
      end else begin
        m_vcnt++;
      end
    end
    m_vsprev = vs;
    @(posedge vga_clk);
    #1;
  endtask

  task automatic vsync_fall();
    blank = 1'b0;
    vs = 1'b0; tick();
    vs = 1'b1; tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 12; i++) begin
      DrawX = 10'($urandom_range(0, 639));
      DrawY = 10'($urandom_range(0, 479));
      blank = 1'($urandom); vs = 1'($urandom);
      anim_en = 1'($urandom); frame_sel = 2'($urandom);
      sprite_x = 10'($urandom); sprite_y = 10'($urandom);
      scale_log2 = 2'($urandom);
      @(posedge vga_clk); #1;
      checks++;
      if (pix_on !== 1'b0 || pix_idx !== '0 || rom_address !== '0
          || frame_cur !== '0) begin
        errors++;
        $display("FAIL reset_hold: on=%b idx=%0d addr=%0d frame=%0d exp 0",
                 pix_on, pix_idx, rom_address, frame_cur);
      end
    end
    vs = 1'b1; blank = 1'b0;
    #2 reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (pix_on !== 1'b0 || pix_idx !== '0 || rom_address !== '0
          || frame_cur !== '0) begin
        errors++;
        $display("FAIL reset_release: on=%b idx=%0d addr=%0d frame=%0d exp 0",
                 pix_on, pix_idx, rom_address, frame_cur);
      end
    end
    // Asynchronous clear away from any clock edge
    sprite_x = 10'd0; sprite_y = 10'd0; scale_log2 = 2'd0;
    for (int i = 0; i < 8; i++) begin
      DrawX = 10'(i); DrawY = 10'd0; blank = 1'b1; tick();
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (pix_on !== 1'b0 || pix_idx !== '0 || rom_address !== '0) begin
      errors++;
      $display("FAIL reset_async: on=%b idx=%0d addr=%0d exp 0",
               pix_on, pix_idx, rom_address);
    end
    blank = 1'b0;
    @(posedge vga_clk); #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic scan(string nm, int x0, int x1, int y0, int y1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) begin
        DrawX = 10'(x); DrawY = 10'(y); blank = 1'b1;
        tick();
        checks++;
        if (rom_address !== AW'(m_addr1) || pix_on !== m_on3
            || pix_idx !== IDX_W'(m_idx3)) begin
          errors++;
          $display("FAIL %s @(%0d,%0d): addr=%0d on=%b idx=%0d exp addr=%0d on=%b idx=%0d",
                   nm, x, y, rom_address, pix_on, pix_idx,
                   m_addr1, m_on3, m_idx3);
        end
      end
  endtask

  task automatic test_placement();
    for (int i = 0; i < 4096; i++) rom_mem[i] = IDX_W'(i) | 4'd1;
    anim_en = 1'b0; frame_sel = '0;
    sprite_x = 10'd100; sprite_y = 10'd50; scale_log2 = 2'd0;
    vsync_fall();
    scan("place", 96, 135, 48, 83);
    DrawX = 10'd101; DrawY = 10'd50; blank = 1'b1; tick();
    checks++;
    if (rom_address !== 12'd1) begin
      errors++;
      $display("FAIL place_addr: got %0d exp 1", rom_address);
    end
    blank = 1'b0; tick(); tick();
    checks++;
    if (pix_on !== 1'b1 || pix_idx !== 4'd1) begin
      errors++;
      $display("FAIL place_pix: on=%b idx=%0d exp on=1 idx=1", pix_on, pix_idx);
    end
  endtask

  task automatic test_scaling();
    sprite_x = 10'd0; sprite_y = 10'd0; scale_log2 = 2'd2;
    vsync_fall();
    DrawX = 10'd7; DrawY = 10'd7; blank = 1'b1; tick();
    checks++;
    if (rom_address !== 12'h021) begin
      errors++;
      $display("FAIL scale_addr: got %0h exp 21", rom_address);
    end
    DrawX = 10'd128; DrawY = 10'd0; tick();
    blank = 1'b0; tick(); tick();
    checks++;
    if (pix_on !== 1'b0) begin
      errors++;
      $display("FAIL scale_edge: on=%b exp 0", pix_on);
    end
    for (int i = 0; i < 400; i++) begin
      DrawX = 10'($urandom_range(0, 160));
      DrawY = 10'($urandom_range(0, 160));
      blank = 1'b1; tick();
      checks++;
      if (rom_address !== AW'(m_addr1) || pix_on !== m_on3
          || pix_idx !== IDX_W'(m_idx3)) begin
        errors++;
        $display("FAIL scale_rand: addr=%0d on=%b idx=%0d exp %0d %b %0d",
                 rom_address, pix_on, pix_idx, m_addr1, m_on3, m_idx3);
      end
    end
  endtask

  task automatic test_transparency_clip();
    for (int i = 0; i < 4096; i++) rom_mem[i] = IDX_W'(KEY);
    sprite_x = 10'd10; sprite_y = 10'd10; scale_log2 = 2'd0;
    vsync_fall();
    for (int i = 0; i < 300; i++) begin
      DrawX = 10'($urandom_range(10, 41));
      DrawY = 10'($urandom_range(10, 41));
      blank = 1'b1; tick();
      checks++;
      if (pix_on !== 1'b0 || pix_idx !== '0) begin
        errors++;
        $display("FAIL key: on=%b idx=%0d exp on=0 idx=0", pix_on, pix_idx);
      end
    end
    for (int i = 0; i < 4096; i++)
      rom_mem[i] = ($urandom_range(0, 3) == 0) ? IDX_W'(KEY) : IDX_W'($urandom);
    sprite_x = 10'd620; sprite_y = 10'd470;
    vsync_fall();
    scan("clip", 0, 639, 466, 479);
    scan("clip_top", 0, 639, 0, 1);
    for (int i = 0; i < 200; i++) begin
      DrawX = 10'($urandom_range(620, 639));
      DrawY = 10'($urandom_range(470, 479));
      blank = 1'b0; tick();
      checks++;
      if (pix_on !== 1'b0 || pix_idx !== IDX_W'(m_idx3)) begin
        errors++;
        $display("FAIL blank: on=%b idx=%0d exp on=0 idx=%0d",
                 pix_on, pix_idx, m_idx3);
      end
    end
  endtask

  task automatic test_animation();
    int exp_seq[6] = '{0, 1, 1, 2, 2, 0};
    anim_en = 1'b0; frame_sel = 2'd0;
    vsync_fall();
    anim_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      vsync_fall();
      checks++;
      if (frame_cur !== FW'(exp_seq[i]) || m_frame != exp_seq[i]) begin
        errors++;
        $display("FAIL anim_step%0d: frame=%0d exp %0d", i, frame_cur, exp_seq[i]);
      end
    end
    anim_en = 1'b0; frame_sel = 2'd1;
    vsync_fall();
    checks++;
    if (frame_cur !== 2'd1) begin
      errors++;
      $display("FAIL anim_sel1: frame=%0d exp 1", frame_cur);
    end
    frame_sel = 2'd3;
    vsync_fall();
    checks++;
    if (frame_cur !== 2'd0) begin
      errors++;
      $display("FAIL anim_sel3: frame=%0d exp 0", frame_cur);
    end
    // anim_en rises on the same edge as the fall
    frame_sel = 2'd2; vsync_fall();
    blank = 1'b0; vs = 1'b0; anim_en = 1'b1; tick();
    vs = 1'b1; tick();
    vs = 1'b0; tick();
    vs = 1'b1; tick();
    checks++;
    if (frame_cur !== FW'(m_frame) || m_frame != 0) begin
      errors++;
      $display("FAIL anim_toggle: frame=%0d exp %0d", frame_cur, m_frame);
    end
    anim_en = 1'b0; frame_sel = 2'd0; vsync_fall();
  endtask

  task automatic test_shadowing();
    for (int i = 0; i < 4096; i++) rom_mem[i] = IDX_W'(i) | 4'd1;
    sprite_x = 10'd200; sprite_y = 10'd100; scale_log2 = 2'd0;
    vsync_fall();
    scan("shadow_a", 190, 240, 110, 110);
    sprite_x = 10'd300; sprite_y = 10'd300; scale_log2 = 2'd1;
    scan("shadow_b", 190, 340, 111, 111);
    DrawX = 10'd205; DrawY = 10'd112; blank = 1'b1; tick();
    blank = 1'b0; tick(); tick();
    checks++;
    if (pix_on !== 1'b1) begin
      errors++;
      $display("FAIL shadow_hold: on=%b exp 1", pix_on);
    end
    vsync_fall();
    scan("shadow_c", 190, 380, 300, 301);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4096; i++)
      rom_mem[i] = ($urandom_range(0, 4) == 0) ? IDX_W'(KEY) : IDX_W'($urandom);
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) begin
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (pix_on !== 1'b0 || rom_address !== '0 || frame_cur !== '0) begin
          errors++;
          $display("FAIL rand_reset: on=%b addr=%0d frame=%0d exp 0",
                   pix_on, rom_address, frame_cur);
        end
        vs = 1'b1;
        @(posedge vga_clk); #1;
        reset_n = 1'b1;
        model_reset();
      end
      DrawX = 10'($urandom_range(0, 639));
      DrawY = 10'($urandom_range(0, 479));
      blank = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) vs = ~vs;
      if ($urandom_range(0, 63) == 0) anim_en = 1'($urandom);
      if ($urandom_range(0, 31) == 0) begin
        frame_sel = 2'($urandom);
        sprite_x = 10'($urandom_range(0, 700));
        sprite_y = 10'($urandom_range(0, 520));
        scale_log2 = 2'($urandom);
      end
      tick();
      checks++;
      if (rom_address !== AW'(m_addr1) || pix_on !== m_on3
          || pix_idx !== IDX_W'(m_idx3) || frame_cur !== FW'(m_frame)) begin
        errors++;
        $display("FAIL rand%0d: addr=%0d on=%b idx=%0d fr=%0d exp %0d %b %0d %0d",
                 i, rom_address, pix_on, pix_idx, frame_cur,
                 m_addr1, m_on3, m_idx3, m_frame);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom_mem[i] = '0;
    model_reset();
    test_reset();
    test_placement();
    test_scaling();
    test_transparency_clip();
    test_animation();
    test_shadowing();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
